// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
// Bundles every request, result and status signal exchanged between the
// pipeline (master) and the register-file write arbiter (slave).
//   master : drives wb_*, mdu_valid/dest/val, issue_*, src1/src2;
//            observes mdu_ready, rf_*, hazards, wb_stall_req, pending
//   slave  : the arbiter side, the mirror image of master
interface rf_write_arbiter_if;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_val;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_val;
  logic        mdu_ready;
  logic        issue_en;
  logic [4:0]  issue_dest;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        rf_we;
  logic [4:0]  rf_dest;
  logic [31:0] rf_wval;
  logic        hazard1;
  logic        hazard2;
  logic        issue_conflict;
  logic        wb_stall_req;
  logic [31:0] pending;

  modport master (
    output wb_en, wb_dest, wb_val,
    output mdu_valid, mdu_dest, mdu_val,
    output issue_en, issue_dest, src1, src2,
    input  mdu_ready, rf_we, rf_dest, rf_wval,
    input  hazard1, hazard2, issue_conflict, wb_stall_req, pending
  );

  modport slave (
    input  wb_en, wb_dest, wb_val,
    input  mdu_valid, mdu_dest, mdu_val,
    input  issue_en, issue_dest, src1, src2,
    output mdu_ready, rf_we, rf_dest, rf_wval,
    output hazard1, hazard2, issue_conflict, wb_stall_req, pending
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between the never-stalled WB
// stage and a long-latency unit (MDU). Unit results wait in a 2-entry FIFO
// and are written whenever WB leaves the port idle. A saturating wait counter
// asks the pipeline for a bubble when the FIFO head starves too long.
// Optional register scoreboard (macro RF_SCOREBOARD_EN) tracks destinations
// reserved by issued long-latency ops and flags source/issue hazards.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_write_arbiter_if.slave (WB request, MDU offer/ready,
//              issue reservation, ID sources, RF write port, stall flags,
//              pending mask)
// Parameter:
//   STARVE_LIMIT : blocked cycles before wb_stall_req (1..7)
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [1:0]  count;
  logic [4:0]  q_dest [2];
  logic [31:0] q_val  [2];
  logic [2:0]  wait_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  assign fifo_empty    = (count == 2'd0);
  assign fifo_full     = (count == 2'd2);
  // Ready comes from registered count only, so it never depends on wb_en.
  assign bus.mdu_ready = !rst && !fifo_full;
  assign push          = bus.mdu_valid && bus.mdu_ready;
  // The head is written (and retired) in any cycle WB leaves the port free.
  assign pop           = !rst && !bus.wb_en && !fifo_empty;

  // Write-port mux: WB always wins, FIFO head fills idle slots; the data
  // lines are forced to zero whenever nothing is written.
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_dest = 5'd0;
    bus.rf_wval = 32'd0;
    if (!rst) begin
      if (bus.wb_en) begin
        bus.rf_we   = 1'b1;
        bus.rf_dest = bus.wb_dest;
        bus.rf_wval = bus.wb_val;
      end else if (!fifo_empty) begin
        bus.rf_we   = 1'b1;
        bus.rf_dest = q_dest[0];
        bus.rf_wval = q_val[0];
      end
    end
  end

  // Shift-style FIFO: slot 0 is always the head. A push that coincides with
  // a pop can only happen at count 1, so the new entry lands straight in the
  // head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      q_dest[0] <= 5'd0;
      q_dest[1] <= 5'd0;
      q_val[0]  <= 32'd0;
      q_val[1]  <= 32'd0;
    end else begin
      if (push && (pop || fifo_empty)) begin
        q_dest[0] <= bus.mdu_dest;
        q_val[0]  <= bus.mdu_val;
      end else if (pop) begin
        q_dest[0] <= q_dest[1];
        q_val[0]  <= q_val[1];
      end
      if (push && !pop && (count == 2'd1)) begin
        q_dest[1] <= bus.mdu_dest;
        q_val[1]  <= bus.mdu_val;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Starvation counter: counts cycles a queued head is blocked by WB and
  // saturates at 7; any pop or an empty FIFO restarts it.
  always_ff @(posedge clk) begin
    if (rst || pop || fifo_empty) begin
      wait_cnt <= 3'd0;
    end else if (bus.wb_en && (wait_cnt != 3'd7)) begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  assign bus.wb_stall_req = !rst && (wait_cnt >= LIMIT);

`ifdef RF_SCOREBOARD_EN
  logic [31:0] pending_q;
  logic        set_en;

  assign bus.issue_conflict = bus.issue_en && pending_q[bus.issue_dest];
  // r0 is hard-wired, so reserving it would only create false hazards.
  assign set_en       = bus.issue_en && !bus.issue_conflict &&
                        (bus.issue_dest != 5'd0);
  assign bus.pending  = pending_q;
  assign bus.hazard1  = pending_q[bus.src1];
  assign bus.hazard2  = pending_q[bus.src2];

  // Reservation mask: the clear for a retiring head is written first so a
  // same-cycle re-reservation of that register takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 32'd0;
    end else begin
      if (pop) begin
        pending_q[q_dest[0]] <= 1'b0;
      end
      if (set_en) begin
        pending_q[bus.issue_dest] <= 1'b1;
      end
    end
  end
`else
  logic unused_sb;

  assign unused_sb          = ^{bus.issue_en, bus.issue_dest, bus.src1, bus.src2};
  assign bus.pending        = 32'd0;
  assign bus.hazard1        = 1'b0;
  assign bus.hazard2        = 1'b0;
  assign bus.issue_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Self-checking bench for rf_write_arbiter (STARVE_LIMIT = 4). A reference
// model of the FIFO, wait counter and scoreboard predicts each cycle's write
// port drive; predictions go into a queue at drive time and are popped and
// compared against the DUT's write port. Honours RF_SCOREBOARD_EN.
module tb_rf_write_arbiter;

`ifdef RF_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] val;
  } entry_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] val;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  entry_t      mq[$];
  wr_t         sbq[$];
  int          m_wait;
  logic [31:0] m_pending;
  int          n_compared;
  int          n_mismatched;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pops the oldest predicted write and checks the DUT's write port.
  task automatic monitorWrite();
    wr_t e;
    if (sbq.size() == 0) begin
      checkOutput("sbq_empty", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    checkOutput("rf_we",   32'(bus.rf_we),   32'(e.we));
    checkOutput("rf_dest", 32'(bus.rf_dest), 32'(e.dest));
    checkOutput("rf_wval", bus.rf_wval,      e.val);
  endtask

  // One non-reset cycle: drive, predict, compare, then advance the model.
  task automatic applyStimulus(input bit wen, input logic [4:0] wd,
                               input logic [31:0] wv, input bit mv,
                               input logic [4:0] md, input logic [31:0] mval,
                               input bit ie, input logic [4:0] id,
                               input logic [4:0] s1, input logic [4:0] s2);
    wr_t    e;
    bit     ready;
    bit     conf;
    bit     do_pop;
    bit     do_push;
    int     size_before;
    entry_t head;
    @(negedge clk);
    rst            = 1'b0;
    bus.wb_en      = wen;
    bus.wb_dest    = wd;
    bus.wb_val     = wv;
    bus.mdu_valid  = mv;
    bus.mdu_dest   = md;
    bus.mdu_val    = mval;
    bus.issue_en   = ie;
    bus.issue_dest = id;
    bus.src1       = s1;
    bus.src2       = s2;
    size_before = mq.size();
    e = '0;
    if (wen) begin
      e.we = 1'b1; e.dest = wd; e.val = wv;
    end else if (size_before > 0) begin
      e.we = 1'b1; e.dest = mq[0].dest; e.val = mq[0].val;
    end
    sbq.push_back(e);
    ready = (size_before < 2);
    conf  = ie && m_pending[id];
    #1;
    monitorWrite();
    checkOutput("mdu_ready",      32'(bus.mdu_ready),      32'(ready));
    checkOutput("wb_stall_req",   32'(bus.wb_stall_req),   32'(m_wait >= LIMIT));
    checkOutput("pending",        bus.pending,             m_pending);
    checkOutput("hazard1",        32'(bus.hazard1),        32'(m_pending[s1]));
    checkOutput("hazard2",        32'(bus.hazard2),        32'(m_pending[s2]));
    checkOutput("issue_conflict", 32'(bus.issue_conflict), 32'(conf));
    do_pop  = !wen && size_before > 0;
    do_push = mv && ready;
    head    = (size_before > 0) ? mq[0] : '0;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back('{dest: md, val: mval});
    if (do_pop || size_before == 0) m_wait = 0;
    else if (wen && m_wait < 7) m_wait++;
    if (do_pop) m_pending[head.dest] = 1'b0;
    if (SB_EN && ie && !conf && id != 5'd0) m_pending[id] = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset with busy inputs to show rst overrides push, pop and set.
  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst            = 1'b1;
      bus.wb_en      = 1'b1;
      bus.wb_dest    = 5'd9;
      bus.wb_val     = 32'h1234;
      bus.mdu_valid  = 1'b1;
      bus.mdu_dest   = 5'd4;
      bus.mdu_val    = 32'h55;
      bus.issue_en   = 1'b1;
      bus.issue_dest = 5'd4;
      bus.src1       = 5'd0;
      bus.src2       = 5'd0;
      #1;
      checkOutput("rst_rf_we",     32'(bus.rf_we),        32'd0);
      checkOutput("rst_mdu_ready", 32'(bus.mdu_ready),    32'd0);
      checkOutput("rst_stall",     32'(bus.wb_stall_req), 32'd0);
    end
    mq.delete();
    m_wait    = 0;
    m_pending = '0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_wait       = 0;
    m_pending    = '0;
    doReset(2);
    idle(1);

    // WB write with empty FIFO goes straight through.
    applyStimulus(1, 5'd5, 32'hAA, 0, 0, 0, 0, 0, 0, 0);

    // Reserve r3, deliver its result, let it drain and clear the reservation.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 0);
    applyStimulus(0, 0, 0, 1, 5'd3, 32'h11, 0, 0, 5'd3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
    idle(1);

    // Fill FIFO under WB traffic, starve it, then drain in order.
    applyStimulus(1, 5'd1, 32'h101, 1, 5'd10, 32'hA0, 0, 0, 0, 0);
    applyStimulus(1, 5'd2, 32'h102, 1, 5'd11, 32'hA1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 5'(12 + i), 32'(200 + i), 1, 5'd20, 32'hDEAD, 0, 0, 0, 0);
    idle(3);

    // Reservation of r7: hazard, conflicting re-issue, release on retire.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);

    // r0 is never reserved; r9 reservation seen on src2.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9);

    // Reset mid-queue discards both entries and the reservations.
    applyStimulus(1, 5'd1, 32'h1, 1, 5'd9, 32'h9, 0, 0, 0, 0);
    applyStimulus(1, 5'd1, 32'h2, 1, 5'd8, 32'h8, 1, 5'd8, 0, 0);
    doReset(1);
    idle(2);

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset(1);
      applyStimulus($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                    $urandom, $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 3) == 0, 5'($urandom_range(0, 15)),
                    5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning cycles a queued unit result may wait before bubble request (range 1..7).
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wb_en / wb_dest / wb_val  input  1/5/32  pipeline WB-stage write request (never stalled).
REQ-005 SHALL have port mdu_valid / mdu_dest / mdu_val  input  1/5/32  long-latency unit result offer.
REQ-006 SHALL have port mdu_ready  output  1  result accepted this cycle when high with mdu_valid.
REQ-007 SHALL have port issue_en / issue_dest  input  1/5  long-latency op issued, reserving issue_dest.
REQ-008 SHALL have port src1 / src2  input  5/5  ID-stage source register numbers.
REQ-009 SHALL have port rf_we / rf_dest / rf_wval  output  1/5/32  register-file write port drive.
REQ-010 SHALL have port hazard1 / hazard2 / issue_conflict  output  1/1/1  stall indications.
REQ-011 SHALL have port wb_stall_req  output  1  request pipeline bubble so WB slot frees.
REQ-012 SHALL have port pending  output  32  scoreboard mask, bit n = register n reserved.

Function
REQ-013 SHALL queue accepted unit results in a 2-entry FIFO; mdu_ready = !full, derived from registered count only.
REQ-014 SHALL push on mdu_valid & mdu_ready; push and pop in same cycle at count 1 SHALL leave count 1 with new head = pushed entry.
REQ-015 SHALL drive rf_* combinationally: wb_en=1 -> WB request wins; else FIFO non-empty -> FIFO head; else rf_we=0.
REQ-016 SHALL pop FIFO head at the posedge ending any cycle where head drove rf_we; WB request SHALL never be delayed or dropped.
REQ-017 SHALL keep rf_dest/rf_wval = 0 when rf_we=0.
REQ-018 SHALL keep wait counter (3-bit, saturating): cleared on pop or when empty, else +1 per cycle head is blocked by wb_en.
REQ-019 SHALL assert wb_stall_req while wait counter >= STARVE_LIMIT; deasserts the cycle after pop.
REQ-020 SHALL, when scoreboard compiled in, set pending[issue_dest] on issue_en with issue_dest != 0; bit 0 SHALL never set.
REQ-021 SHALL clear pending[d] when a FIFO head with dest d pops; simultaneous set and clear of same bit -> set wins.
REQ-022 SHALL drive hazard1 = pending[src1], hazard2 = pending[src2], issue_conflict = issue_en & pending[issue_dest], all combinational.
REQ-023 SHALL not alter scoreboard on WB-path writes.
REQ-024 SHALL ignore mdu_valid while full (no overwrite) and issue_en when issue_conflict=1.

Reset
REQ-025 SHALL, on rst at posedge, empty FIFO, clear count, wait counter and pending; rst overrides simultaneous push, pop, set.
REQ-026 SHALL hold rf_we=0, mdu_ready=0, wb_stall_req=0 while rst=1, including reset mid-queue (queued results discarded).

Configuration
REQ-027 SHALL compile scoreboard in only when macro RF_SCOREBOARD_EN is defined; when absent, pending=0, hazard1=hazard2=issue_conflict=0 and no scoreboard registers exist; FIFO, arbitration and starvation logic unchanged.

Verification
REQ-028 SHALL cover: wb_en=1 dest 5 val 0xAA, FIFO empty -> rf_we=1, rf_dest=5, rf_wval=0xAA same cycle.
REQ-029 SHALL cover: push dest 3 val 0x11 with wb_en=0 next cycle -> rf_we=1 dest 3 next cycle, FIFO empty after, pending[3] cleared.
REQ-030 SHALL cover: two pushes then wb_en held 4 cycles (STARVE_LIMIT=4) -> mdu_ready=0 while full, wb_stall_req=1 after 4th blocked cycle, both entries written in order after wb_en drops.
REQ-031 SHALL cover: issue_en dest 7 then src1=7 -> hazard1=1; second issue_en dest 7 -> issue_conflict=1; result dest 7 pops -> hazard1=0 next cycle.
REQ-032 SHALL cover: issue_en dest 0 -> pending=0; rst asserted with 2 queued entries -> count 0, pending 0, rf_we=0 next cycle.
REQ-033 SHALL cover: build without RF_SCOREBOARD_EN, issue_en dest 9, src2=9 -> hazard2=0, pending=0.
